// File: rtl/nt_trigger_tx.sv
// Serial trigger-pattern transmitter: shifts a parallel word out LSB-first and drives
// a GAP-delayed active-low qualifier. Optional even-parity bit via NT_TX_PARITY_EN.
module nt_trigger_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             blk_clk,
    input  logic             blk_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             qual_n,
    output logic             done,
    output logic [1:0]       dbg_state
);

`ifdef NT_TX_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam int DW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int PW = (GAP > 0) ? GAP : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  frame;
    logic [N-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    logic [PW-1:0] vpipe;
    logic          accept;
    logic          last_bit;
    logic          bv_next;
    logic          qual_src;

`ifdef NT_TX_PARITY_EN
    assign frame = {^in_data, in_data};
`else
    assign frame = in_data;
`endif

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both
    // high; in_ready is high only in IDLE, and abort at that edge cancels the transfer.
    assign accept    = in_valid & in_ready & ~abort;
    assign last_bit  = (cnt >= CW'(N));
    assign dbg_state = state;

    // Bit-valid flag for the next cycle: high whenever a frame bit will be on ser_out.
    always_comb begin
        bv_next = 1'b0;
        case (state)
            IDLE:    bv_next = accept;
            SHIFT:   bv_next = ~abort & ~last_bit;
            default: bv_next = 1'b0;
        endcase
    end

    generate
        if (GAP == 0) begin : g_nodelay
            assign qual_src = bv_next;
        end else begin : g_delay
            assign qual_src = vpipe[GAP-1];
        end
    endgenerate

    always_ff @(posedge blk_clk or negedge blk_rst) begin
        if (!blk_rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            ser_out  <= 1'b0;
            qual_n   <= 1'b1;
            done     <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            vpipe    <= '0;
        end else if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            ser_out  <= 1'b0;
            qual_n   <= 1'b1;
            done     <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            vpipe    <= '0;
        end else begin
            done   <= 1'b0;
            vpipe  <= PW'({vpipe, bv_next});
            qual_n <= ~qual_src;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg     <= frame >> 1;
                        ser_out  <= frame[0];
                        cnt      <= CW'(1);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        ser_out <= 1'b0;
                        cnt     <= '0;
                        if (GAP == 0) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            dcnt  <= DW'(1);
                        end
                    end else begin
                        ser_out <= sreg[0];
                        sreg    <= sreg >> 1;
                        if (cnt != {CW{1'b1}}) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Hold off done until the last qualified bit has left the pipe.
                    if (dcnt >= DW'(GAP)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        done     <= 1'b1;
                        dcnt     <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nt_trigger_tx.sv
// Bench for nt_trigger_tx (WIDTH=8, GAP=2): table-driven frames with per-cycle
// expectations plus a serial-bit scoreboard checked through the qualifier window.
module tb_nt_trigger_tx;

    localparam int W = 8;
    localparam int G = 2;
`ifdef NT_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int DONE_AT = NB + G + 1;

    logic         blk_clk = 1'b0;
    logic         blk_rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         abort = 1'b0;
    logic         ser_out;
    logic         qual_n;
    logic         done;
    logic [1:0]   dbg_state;

    nt_trigger_tx #(.WIDTH(W), .GAP(G)) dut (
        .blk_clk   (blk_clk),
        .blk_rst   (blk_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .ser_out   (ser_out),
        .qual_n    (qual_n),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 blk_clk = ~blk_clk;

    typedef struct {
        logic [W-1:0] data;
        int           abort_at;
        int           done_at;
    } vec_t;

    int     n_checks = 0;
    int     n_fail = 0;
    int     done_seen = 0;
    int     exp_dones = 0;
    logic   exp_q[$];
    logic [G-1:0] hist = '0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [W-1:0] d);
`ifdef NT_TX_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic push_frame(input logic [W-1:0] d);
        logic [NB-1:0] f;
        f = frame_of(d);
        for (int i = 0; i < NB; i++) exp_q.push_back(f[i]);
    endtask

    task automatic step();
        @(posedge blk_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_rdy"}, in_ready, 1'b1);
        check_bit({tag, "_ser"}, ser_out, 1'b0);
        check_bit({tag, "_qual"}, qual_n, 1'b1);
        check_bit({tag, "_done"}, done, 1'b0);
    endtask

    // Detector view: when qual_n is low, the bit sent G cycles earlier is the frame bit.
    always @(negedge blk_clk) begin
        if (!blk_rst) begin
            hist <= '0;
        end else begin
            hist <= G'({hist, ser_out});
            if (done) done_seen++;
            if (!qual_n) begin
                check_int("sb_avail", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) check_bit("sb_bit", hist[G-1], exp_q.pop_front());
            end
        end
    end

    task automatic run_frame(input vec_t v, input string tag);
        logic [NB-1:0] f;
        logic          live;
        logic          e_ser;
        logic          e_rdy;
        f = frame_of(v.data);
        check_bit({tag, "_rdy0"}, in_ready, 1'b1);
        in_data  = v.data;
        in_valid = 1'b1;
        abort    = 1'b0;
        push_frame(v.data);
        for (int k = 1; k <= DONE_AT + 1; k++) begin
            step();
            if (v.abort_at != 0 && k == v.abort_at + 1) exp_q.delete();
            live  = (v.abort_at == 0) || (k <= v.abort_at);
            e_ser = 1'b0;
            if (k <= NB && live) e_ser = f[k-1];
            e_rdy = (v.abort_at != 0) ? (k > v.abort_at) : (k >= DONE_AT);
            check_bit($sformatf("%s_ser_c%0d", tag, k), ser_out, e_ser);
            check_bit($sformatf("%s_qual_c%0d", tag, k), qual_n,
                      !(live && k >= 1 + G && k <= NB + G));
            check_bit($sformatf("%s_done_c%0d", tag, k), done, k == v.done_at);
            check_bit($sformatf("%s_rdy_c%0d", tag, k), in_ready, e_rdy);
            // Junk on the input side while busy must be ignored.
            in_data  = W'($urandom_range(0, 255));
            in_valid = e_rdy ? 1'b0 : 1'($urandom_range(0, 1));
            abort    = (k == v.abort_at);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        if (v.done_at != 0) exp_dones++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [NB-1:0] f0;
        logic [NB-1:0] f1;
        logic          e_ser;
        int            j;

        vecs[0] = '{8'hA5, 0, DONE_AT};
        vecs[1] = '{8'h3C, 0, DONE_AT};
        vecs[2] = '{8'h00, 0, DONE_AT};
        vecs[3] = '{8'hFF, 5, 0};
        vecs[4] = '{8'h81, NB + 1, 0};
        vecs[5] = '{8'h01, 1, 0};
        vecs[6] = '{W'($urandom_range(0, 255)), 0, DONE_AT};
        vecs[7] = '{W'($urandom_range(0, 255)), 0, DONE_AT};

        // Reset behaviour and quiet idle after release.
        #12;
        check_idle("rst");
        check_int("rst_state", int'(dbg_state), 0);
        @(negedge blk_clk);
        blk_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle($sformatf("idle%0d", k));
        end

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // Back-to-back frames with in_valid held high; data changes after accept.
        f0 = frame_of(8'hA5);
        f1 = frame_of(8'h3C);
        check_bit("b2b_rdy0", in_ready, 1'b1);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        push_frame(8'hA5);
        for (int k = 1; k <= 2 * DONE_AT + 1; k++) begin
            step();
            j     = (k <= DONE_AT) ? k : k - DONE_AT;
            e_ser = 1'b0;
            if (j >= 1 && j <= NB) e_ser = (k <= DONE_AT) ? f0[j-1] : f1[j-1];
            check_bit($sformatf("b2b_ser_c%0d", k), ser_out, e_ser);
            check_bit($sformatf("b2b_qual_c%0d", k), qual_n,
                      !((k - G >= 1 && k - G <= NB) ||
                        (k - G - DONE_AT >= 1 && k - G - DONE_AT <= NB)));
            check_bit($sformatf("b2b_done_c%0d", k), done,
                      (k == DONE_AT) || (k == 2 * DONE_AT));
            check_bit($sformatf("b2b_rdy_c%0d", k), in_ready,
                      (k == DONE_AT) || (k >= 2 * DONE_AT));
            in_data = 8'h3C;
            if (k == DONE_AT) push_frame(8'h3C);
            in_valid = (k <= DONE_AT);
        end
        in_valid = 1'b0;
        exp_dones += 2;

        // Abort in IDLE blocks the accept at that edge.
        in_data  = 8'h5A;
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        check_idle("idle_abort");
        check_int("idle_abort_state", int'(dbg_state), 0);
        step();
        check_idle("idle_abort2");

        // Asynchronous reset in the middle of SHIFT.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        push_frame(8'hA5);
        step();
        in_valid = 1'b0;
        step();
        step();
        check_bit("mid_ser_c3", ser_out, 1'b1);
        check_bit("mid_qual_c3", qual_n, 1'b0);
        blk_rst = 1'b0;
        #1;
        exp_q.delete();
        check_idle("mid_rst");
        check_int("mid_rst_state", int'(dbg_state), 0);
        step();
        step();
        @(negedge blk_clk);
        blk_rst = 1'b1;
        step();
        run_frame(vecs[0], "post_rst");

        step();
        step();
        check_int("sb_empty", exp_q.size(), 0);
        check_int("done_count", done_seen, exp_dones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
